// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//   Command sequencer between a byte-level SPI slave and a register bank.
//   Each chip-select frame is one command byte followed by data bytes.
//   Command byte: bit7 = read(1)/write(0), bit6 = auto-increment,
//   bits[ADDR_W-1:0] = start address.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   cs_active     frame select, already synchronised to clk
//   rx_valid      1-cycle pulse, rx_byte holds a completed MOSI byte
//   rx_byte       received byte
//   tx_byte       byte the SPI slave shifts out at the next byte boundary
//   reg_addr      register address, valid with reg_we / reg_re
//   reg_wdata     write data, valid with reg_we
//   reg_we        1-cycle write strobe
//   reg_re        1-cycle read strobe
//   reg_rdata     read data, valid one cycle after reg_re
//   frame_done    1-cycle pulse when an active frame ends
//   wr_count      writes in the last/current frame, saturating at 255
//   ovr_err       sticky: a byte arrived while a read fetch was pending
//
// Handshake: rx_valid is a single-cycle qualifier with no back-pressure; a
// byte is consumed in the cycle rx_valid is high. reg_we/reg_re are
// single-cycle strobes, never both high in the same cycle; reg_rdata is
// sampled exactly one cycle after reg_re.
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int          ADDR_W = 6,
    parameter logic [7:0]  STATUS = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              frame_done,
    output logic [7:0]        wr_count,
    output logic              ovr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RREQ,
        S_RWAIT,
        S_RDATA
    } state_t;

    state_t              state_q, state_d;
    logic                cs_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inc_q, inc_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [7:0]          wr_cnt_q, wr_cnt_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        inc_d    = inc_q;
        tx_d     = tx_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        wr_cnt_d = wr_cnt_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;

        // The write strobe uses addr_q as-is; the increment lands on the
        // edge that ends the strobe cycle, so the next write sees addr+1.
        if (we_q && inc_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = STATUS;
                // cs_q resets high, so a frame already selected at reset
                // release is not mistaken for a new frame.
                if (cs_active && !cs_q) begin
                    state_d  = S_CMD;
                    wr_cnt_d = 8'd0;
                    ovr_d    = 1'b0;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    addr_d  = rx_byte[ADDR_W-1:0];
                    inc_d   = rx_byte[6];
                    state_d = rx_byte[7] ? S_RREQ : S_WDATA;
                end
            end
            S_WDATA: begin
                // Captured even if cs_active falls in this same cycle.
                if (rx_valid) begin
                    we_d    = 1'b1;
                    wdata_d = rx_byte;
                    if (wr_cnt_q != 8'hFF) begin
                        wr_cnt_d = wr_cnt_q + 8'd1;
                    end
                end
            end
            S_RREQ: begin
                state_d = S_RWAIT;
                if (rx_valid) ovr_d = 1'b1;
            end
            S_RWAIT: begin
                tx_d    = reg_rdata;
                state_d = S_RDATA;
                if (rx_valid) ovr_d = 1'b1;
            end
            S_RDATA: begin
                // The incoming byte is the dummy that clocked out tx_byte.
                if (rx_valid) begin
                    if (inc_q) addr_d = addr_q + 1'b1;
                    state_d = S_RREQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame end overrides any pending fetch; read data is dropped.
        if (state_q != S_IDLE && !cs_active) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            tx_d    = STATUS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cs_q     <= 1'b1;
            addr_q   <= '0;
            inc_q    <= 1'b0;
            tx_q     <= STATUS;
            wdata_q  <= 8'd0;
            we_q     <= 1'b0;
            wr_cnt_q <= 8'd0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_active;
            addr_q   <= addr_d;
            inc_q    <= inc_d;
            tx_q     <= tx_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            wr_cnt_q <= wr_cnt_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    // reg_re is a decode of the state register, so rdata returns while the
    // FSM sits in RWAIT and tx_byte refills three cycles after rx_valid.
    assign reg_re     = (state_q == S_RREQ);
    assign reg_we     = we_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign tx_byte    = tx_q;
    assign frame_done = done_q;
    assign wr_count   = wr_cnt_q;
    assign ovr_err    = ovr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_done;
    logic [7:0] wr_count;
    logic       ovr_err;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    logic [13:0] exp_wr_q[$];   // {addr, data}
    logic [5:0]  exp_rd_q[$];   // read addresses
    logic [7:0]  mem[64];

    spi_reg_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cs_active  (cs_active),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .frame_done (frame_done),
        .wr_count   (wr_count),
        .ovr_err    (ovr_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // register-bank stub: data valid one cycle after reg_re
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: pops expected strobes as the DUT produces them
    always @(negedge clk) begin
        if (reg_we && reg_re) chk("we_re_overlap", 1, 0);
        if (reg_we) begin
            if (exp_wr_q.size() == 0) chk("unexpected_write", {18'd0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
            else chk("write", {18'd0, reg_addr, reg_wdata}, {18'd0, exp_wr_q.pop_front()});
        end
        if (reg_re) begin
            if (exp_rd_q.size() == 0) chk("unexpected_read", {26'd0, reg_addr}, 32'hFFFF_FFFF);
            else chk("read_addr", {26'd0, reg_addr}, {26'd0, exp_rd_q.pop_front()});
        end
        if (frame_done) fd_cnt++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_frame();
        cs_active = 1'b1;
        repeat (2) tick();
    endtask

    task automatic end_frame(input int fd_before, input string name);
        cs_active = 1'b0;
        repeat (3) tick();
        chk({name, "_frame_done"}, fd_cnt - fd_before, 1);
        chk({name, "_tx_idle"}, {24'd0, tx_byte}, 32'hA5);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n,
                             input logic [2:0][7:0] d, input logic [7:0] exp_cnt,
                             input string name);
        logic [5:0] a;
        int fd0;
        fd0 = fd_cnt;
        a = cmd[5:0];
        start_frame();
        chk({name, "_tx_status"}, {24'd0, tx_byte}, 32'hA5);
        if (cmd[7]) begin
            exp_rd_q.push_back(a);
            send_byte(cmd, 5);
            chk({name, "_tx0"}, {24'd0, tx_byte}, {24'd0, mem[a]});
            for (int i = 0; i < n; i++) begin
                if (cmd[6]) a = a + 6'd1;
                exp_rd_q.push_back(a);
                send_byte(d[i], 5);
                chk({name, "_txn"}, {24'd0, tx_byte}, {24'd0, mem[a]});
            end
        end else begin
            send_byte(cmd, 5);
            for (int i = 0; i < n; i++) begin
                exp_wr_q.push_back({a, d[i]});
                send_byte(d[i], 5);
                if (cmd[6]) a = a + 6'd1;
            end
        end
        chk({name, "_wr_count"}, {24'd0, wr_count}, {24'd0, exp_cnt});
        end_frame(fd0, name);
    endtask

    typedef struct {
        logic [7:0]      cmd;
        int              n;
        logic [2:0][7:0] d;
        logic [7:0]      exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int fd0;
        logic [7:0] b;

        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[3] = 8'h11;
        mem[4] = 8'h22;

        vecs[0] = '{cmd: 8'h45, n: 2, d: {8'h00, 8'hAD, 8'hDE}, exp_cnt: 8'd2};
        vecs[1] = '{cmd: 8'h7F, n: 2, d: {8'h00, 8'h02, 8'h01}, exp_cnt: 8'd2};
        vecs[2] = '{cmd: 8'h0A, n: 1, d: {8'h00, 8'h00, 8'h33}, exp_cnt: 8'd1};
        vecs[3] = '{cmd: 8'hC3, n: 2, d: {8'h00, 8'h00, 8'h00}, exp_cnt: 8'd0};
        vecs[4] = '{cmd: 8'h85, n: 1, d: {8'h00, 8'h00, 8'hFF}, exp_cnt: 8'd0};

        rst = 1'b1;
        cs_active = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'd0;
        repeat (3) tick();
        chk("rst_tx", {24'd0, tx_byte}, 32'hA5);
        chk("rst_addr", {26'd0, reg_addr}, 0);
        chk("rst_wdata", {24'd0, reg_wdata}, 0);
        chk("rst_strobes", {30'd0, reg_we, reg_re}, 0);
        chk("rst_done_cnt_ovr", {23'd0, frame_done, wr_count, ovr_err}, 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].cmd, vecs[i].n, vecs[i].d, vecs[i].exp_cnt, $sformatf("vec%0d", i));

        // saturation: 300 writes to fixed address 2
        fd0 = fd_cnt;
        start_frame();
        send_byte(8'h02, 4);
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_wr_q.push_back({6'd2, b});
            send_byte(b, 3);
        end
        repeat (2) tick();
        chk("sat_wr_count", {24'd0, wr_count}, 255);
        end_frame(fd0, "sat");

        // overrun: second byte one cycle after the read command
        fd0 = fd_cnt;
        start_frame();
        exp_rd_q.push_back(6'd8);
        rx_valid = 1'b1;
        rx_byte = 8'h88;
        tick();
        rx_byte = 8'hFF;
        tick();
        rx_valid = 1'b0;
        repeat (5) tick();
        chk("ovr_set", {31'd0, ovr_err}, 1);
        chk("ovr_tx", {24'd0, tx_byte}, {24'd0, mem[8]});
        end_frame(fd0, "ovr");
        chk("ovr_sticky", {31'd0, ovr_err}, 1);
        fd0 = fd_cnt;
        start_frame();
        chk("ovr_cleared", {31'd0, ovr_err}, 0);
        end_frame(fd0, "ovr2");

        // cs drop during RWAIT: fetch abandoned
        fd0 = fd_cnt;
        start_frame();
        exp_rd_q.push_back(6'd10);
        rx_valid = 1'b1;
        rx_byte = 8'h8A;
        tick();
        rx_valid = 1'b0;
        tick();
        end_frame(fd0, "abort_rwait");
        repeat (4) tick();
        chk("abort_rwait_tx", {24'd0, tx_byte}, 32'hA5);

        // last write byte coincides with cs fall
        fd0 = fd_cnt;
        start_frame();
        send_byte(8'h20, 5);
        exp_wr_q.push_back({6'h20, 8'hEE});
        rx_valid = 1'b1;
        rx_byte = 8'hEE;
        end_frame(fd0, "wr_at_fall");
        rx_valid = 1'b0;
        chk("wr_at_fall_count", {24'd0, wr_count}, 1);

        // reset in mid-WDATA, frame still selected afterwards
        start_frame();
        send_byte(8'h4C, 5);
        exp_wr_q.push_back({6'd12, 8'h5A});
        send_byte(8'h5A, 5);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_byte = 8'h77;
        tick();
        rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_tx", {24'd0, tx_byte}, 32'hA5);
        chk("rst_mid_addr", {26'd0, reg_addr}, 0);
        chk("rst_mid_count", {24'd0, wr_count}, 0);
        send_byte(8'h99, 5);
        send_byte(8'h98, 5);
        fd0 = fd_cnt;
        cs_active = 1'b0;
        repeat (3) tick();
        chk("rst_mid_no_done", fd_cnt - fd0, 0);
        run_frame(8'h03, 1, {8'h00, 8'h00, 8'h44}, 8'd1, "recover");

        repeat (5) tick();
        chk("wr_queue_empty", exp_wr_q.size(), 0);
        chk("rd_queue_empty", exp_rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
